// File: rtl/nios_system_cpu_3_oci_dtrace_packer.sv
// Packs 2-bit compressed trace codes into 15-slot frames with a one-deep frame register.
// Optional drop counter enabled by defining DTRACE_DROP_CNT_EN.
module nios_system_cpu_3_oci_dtrace_packer #(
  parameter int IDLE_FLUSH_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        code_valid,
  input  logic [1:0]  code,
  input  logic        flush,
  output logic        code_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        frm_valid,
  output logic [33:0] frm_data,
  input  logic        frm_ready,
  output logic [7:0]  drop_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_SEALED = 2'd2;
  localparam logic       FLUSH_EN    = (IDLE_FLUSH_CYCLES > 32'sd0);
  localparam logic [7:0] FLUSH_LIMIT = IDLE_FLUSH_CYCLES[7:0];

  logic [1:0]  state_q, state_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        frm_valid_q, frm_valid_d;
  logic [33:0] frm_data_q, frm_data_d;
  logic [7:0]  timer_q, timer_d;
  logic        code_ready_q, code_ready_d;

  logic        accept_s;
  logic [29:0] m_buf_s;
  logic [3:0]  m_cnt_s;
  logic [7:0]  timer_inc_s;
  logic        idle_flush_s;
  logic        seal_s;
  logic        frm_free_s;

  // Merge the presented code into the accumulator view used by every transition.
  always_comb begin
    accept_s = code_valid && code_ready_q;
    if (accept_s) begin
      m_buf_s = buf_q | ({28'd0, code} << {cnt_q, 1'b0});
      m_cnt_s = cnt_q + 4'd1;
    end else begin
      m_buf_s = buf_q;
      m_cnt_s = cnt_q;
    end
  end

  // Idle timer: counts quiet cycles in FILL and raises a flush one cycle before the limit edge.
  always_comb begin
    timer_inc_s  = timer_q + 8'd1;
    idle_flush_s = FLUSH_EN && (state_q == ST_FILL) && !accept_s && (timer_inc_s == FLUSH_LIMIT);
    if (FLUSH_EN && (state_q == ST_FILL) && !accept_s && !seal_s) begin
      timer_d = timer_inc_s;
    end else begin
      timer_d = 8'd0;
    end
  end

  // Seal decision, frame-register handoff and state transitions.
  always_comb begin
    frm_free_s  = !frm_valid_q || frm_ready;
    seal_s      = (state_q != ST_SEALED) &&
                  ((m_cnt_s == 4'd15) || ((flush || idle_flush_s) && (m_cnt_s != 4'd0)));
    state_d     = state_q;
    buf_d       = m_buf_s;
    cnt_d       = m_cnt_s;
    frm_valid_d = frm_valid_q && !frm_ready;
    frm_data_d  = frm_data_q;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (seal_s && frm_free_s) begin
          frm_data_d  = {m_cnt_s, m_buf_s};
          frm_valid_d = 1'b1;
          buf_d       = 30'd0;
          cnt_d       = 4'd0;
          state_d     = ST_IDLE;
        end else if (seal_s) begin
          state_d = ST_SEALED;
        end else begin
          state_d = (m_cnt_s == 4'd0) ? ST_IDLE : ST_FILL;
        end
      end
      ST_SEALED: begin
        if (frm_free_s) begin
          frm_data_d  = {cnt_q, buf_q};
          frm_valid_d = 1'b1;
          buf_d       = 30'd0;
          cnt_d       = 4'd0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_SEALED;
        end
      end
      default: begin
        buf_d   = 30'd0;
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
    code_ready_d = (state_d != ST_SEALED);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      buf_q        <= 30'd0;
      cnt_q        <= 4'd0;
      frm_valid_q  <= 1'b0;
      frm_data_q   <= 34'd0;
      timer_q      <= 8'd0;
      code_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      frm_valid_q  <= frm_valid_d;
      frm_data_q   <= frm_data_d;
      timer_q      <= timer_d;
      code_ready_q <= code_ready_d;
    end
  end

  assign code_ready = code_ready_q;
  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign frm_valid  = frm_valid_q;
  assign frm_data   = frm_data_q;

`ifdef DTRACE_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  // Saturating count of codes refused while the packer is sealed.
  always_comb begin
    if (code_valid && !code_ready_q && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= 8'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_nios_system_cpu_3_oci_dtrace_packer.sv
// Directed bench with a frame scoreboard; DUT built with a 4-cycle idle flush.
module tb_nios_system_cpu_3_oci_dtrace_packer;

  logic        clk = 1'b0;
  logic        reset_n, code_valid, flush, frm_ready;
  logic [1:0]  code;
  logic        code_ready, frm_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [33:0] frm_data;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];

`ifdef DTRACE_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP = 8'd1;
`else
  localparam logic [7:0] EXP_DROP = 8'd0;
`endif

  always #5 clk = ~clk;

  nios_system_cpu_3_oci_dtrace_packer #(.IDLE_FLUSH_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .code_valid(code_valid), .code(code), .flush(flush),
    .code_ready(code_ready), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .frm_valid(frm_valid), .frm_data(frm_data), .frm_ready(frm_ready), .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    code_valid = 1'b1;
    code       = c;
    cyc();
    code_valid = 1'b0;
  endtask

  // Scoreboard: every handshaken frame must match the oldest expected frame.
  always @(negedge clk) begin
    if (reset_n && frm_valid && frm_ready) begin
      if (exp_q.size() == 0) begin
        chk("frame_expected", 34'(exp_q.size() != 0), 34'd1);
      end else begin
        chk("frame", frm_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; code_valid = 1'b0; code = 2'b00; flush = 1'b0; frm_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_count", 34'(dct_count), 34'd0);
    chk("rst_buffer", 34'(dct_buffer), 34'd0);
    chk("rst_fvalid", 34'(frm_valid), 34'd0);
    chk("rst_fdata", frm_data, 34'd0);
    chk("rst_drop", 34'(drop_count), 34'd0);
    chk("rst_ready", 34'(code_ready), 34'd1);
    reset_n = 1'b1;
    cyc();

    // Full frame of fifteen 2'b01 codes, sealed on the 15th edge.
    frm_ready = 1'b1;
    exp_q.push_back({4'hF, 30'h15555555});
    for (int i = 0; i < 15; i++) send(2'b01);
    chk("full_fvalid", 34'(frm_valid), 34'd1);
    chk("full_fdata", frm_data, {4'hF, 30'h15555555});
    chk("full_count", 34'(dct_count), 34'd0);
    cyc();
    chk("full_drained", 34'(frm_valid), 34'd0);

    // Slot 0 = 3, slot 1 = 1, slot 2 = 2, then flush.
    exp_q.push_back({4'h3, 30'h00000027});
    send(2'b11); send(2'b01); send(2'b10);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush3_fdata", frm_data, {4'h3, 30'h00000027});
    chk("flush3_count", 34'(dct_count), 34'd0);
    cyc();

    // Code and flush in the same cycle seal a one-code frame.
    exp_q.push_back({4'h1, 30'h3});
    flush = 1'b1; send(2'b11); flush = 1'b0;
    chk("flush1_fdata", frm_data, {4'h1, 30'h3});
    cyc();

    // Flush with nothing accumulated produces no frame.
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush0_fvalid", 34'(frm_valid), 34'd0);
    chk("flush0_count", 34'(dct_count), 34'd0);
    chk("flush0_ready", 34'(code_ready), 34'd1);

    // Backpressure: second frame parks in SEALED.
    frm_ready = 1'b0;
    exp_q.push_back({4'hF, 30'h2AAAAAAA});
    exp_q.push_back({4'hF, 30'h3FFFFFFF});
    for (int i = 0; i < 15; i++) send(2'b10);
    chk("bp1_fvalid", 34'(frm_valid), 34'd1);
    chk("bp1_fdata", frm_data, {4'hF, 30'h2AAAAAAA});
    chk("bp1_count", 34'(dct_count), 34'd0);
    for (int i = 0; i < 15; i++) send(2'b11);
    chk("sealed_ready", 34'(code_ready), 34'd0);
    chk("sealed_count", 34'(dct_count), 34'd15);
    chk("sealed_buffer", 34'(dct_buffer), 34'h3FFFFFFF);
    chk("sealed_fdata_held", frm_data, {4'hF, 30'h2AAAAAAA});
    send(2'b01);
    chk("drop_count", 34'(drop_count), 34'(EXP_DROP));
    chk("drop_buffer", 34'(dct_buffer), 34'h3FFFFFFF);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("sealed_flush_count", 34'(dct_count), 34'd15);
    chk("sealed_flush_ready", 34'(code_ready), 34'd0);
    chk("sealed_flush_fdata", frm_data, {4'hF, 30'h2AAAAAAA});
    frm_ready = 1'b1;
    cyc();
    chk("bp2_fdata", frm_data, {4'hF, 30'h3FFFFFFF});
    chk("bp2_fvalid", 34'(frm_valid), 34'd1);
    chk("bp2_count", 34'(dct_count), 34'd0);
    chk("bp2_ready", 34'(code_ready), 34'd1);
    cyc();
    chk("bp_drained", 34'(frm_valid), 34'd0);

    // Idle auto-flush: single code sealed 4 cycles later.
    exp_q.push_back({4'h1, 30'h2});
    send(2'b10);
    chk("idle_count", 34'(dct_count), 34'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_wait", 34'(frm_valid), 34'd0);
    end
    cyc();
    chk("idle_fvalid", 34'(frm_valid), 34'd1);
    chk("idle_fdata", frm_data, {4'h1, 30'h2});
    chk("idle_count0", 34'(dct_count), 34'd0);
    cyc();

    // Reset mid-frame discards both the held frame and the partial one.
    frm_ready = 1'b0;
    flush = 1'b1; send(2'b01); flush = 1'b0;
    for (int i = 0; i < 7; i++) send(2'b10);
    chk("pre_rst_count", 34'(dct_count), 34'd7);
    chk("pre_rst_fvalid", 34'(frm_valid), 34'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_count", 34'(dct_count), 34'd0);
    chk("mid_rst_buffer", 34'(dct_buffer), 34'd0);
    chk("mid_rst_fvalid", 34'(frm_valid), 34'd0);
    chk("mid_rst_fdata", frm_data, 34'd0);
    chk("mid_rst_drop", 34'(drop_count), 34'd0);
    cyc(); cyc();
    reset_n = 1'b1;
    frm_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("post_rst_fvalid", 34'(frm_valid), 34'd0);
    end
    chk("post_rst_count", 34'(dct_count), 34'd0);
    chk("queue_drained", 34'(exp_q.size()), 34'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
